// File: rtl/debug_led_scanner.sv
// Debug LED selector: picks one byte of the debug register space (or the
// controller buttons) for the board LEDs, with switch sync, auto-scroll and sticky capture.
module debug_led_scanner #(
  parameter int NUM_REGS   = 4,
  parameter int REG_W      = 32,
  parameter int SCROLL_DIV = 16777216
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [7:0]                SW,
  input  logic [NUM_REGS*REG_W-1:0] led_regs,
  input  logic [15:0]               buttons,
  output logic [7:0]                LD,
  output logic [5:0]                cur_idx
);

  localparam int REGS_W    = NUM_REGS * REG_W;
  localparam int NUM_BYTES = REGS_W / 8;
  localparam int PRESC_W   = $clog2(SCROLL_DIV);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCROLL_DIV - 1);
  localparam logic [5:0]         LAST_BYTE  = 6'(NUM_BYTES - 1);
  localparam logic [6:0]         BYTE_COUNT = 7'(NUM_BYTES);

  typedef enum logic [1:0] {
    ST_STATIC  = 2'b00,
    ST_BUTTONS = 2'b01,
    ST_SCROLL  = 2'b10,
    ST_STICKY  = 2'b11
  } mode_e;

  // Loop mux keeps every index in range, so an out-of-range index never
  // turns into an out-of-bounds part-select.
  function automatic logic [7:0] pick_byte(input logic [REGS_W-1:0] regs,
                                           input logic [5:0]        idx);
    logic [7:0] sel;
    sel = 8'h00;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (idx == 6'(b)) sel = regs[b*8 +: 8];
    end
    return sel;
  endfunction

  logic [7:0]         sw_meta_q;
  logic [7:0]         sw_s_q;
  logic [5:0]         sw_p_idx_q;
  mode_e              state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0]         scroll_q, scroll_d;
  logic [7:0]         sticky_q, sticky_d;
  logic [7:0]         ld_q, ld_d;
  logic [5:0]         cur_idx_q, cur_idx_d;

  logic [5:0] idx;
  logic       idx_in_range;
  logic [7:0] idx_byte;
  logic       entering;

  assign idx          = sw_s_q[5:0];
  assign idx_in_range = ({1'b0, idx} < BYTE_COUNT);
  assign idx_byte     = pick_byte(led_regs, idx);

  // state_q always equals the previous cycle's synchronised mode, so it
  // doubles as the mode field of sw_p for entry detection.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_STATIC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d   = mode_e'(sw_s_q[7:6]);
    entering  = (state_d != state_q);
    presc_d   = presc_q;
    scroll_d  = scroll_q;
    sticky_d  = sticky_q;
    ld_d      = ld_q;
    cur_idx_d = cur_idx_q;

    case (state_d)
      ST_STATIC: begin
        cur_idx_d = idx;
        ld_d      = idx_in_range ? idx_byte : ~buttons[7:0];
      end
      ST_BUTTONS: begin
        ld_d = sw_s_q[0] ? ~buttons[15:8] : ~buttons[7:0];
      end
      ST_SCROLL: begin
        if (entering) begin
          presc_d  = '0;
          scroll_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d  = '0;
          scroll_d = (scroll_q == LAST_BYTE) ? 6'd0 : scroll_q + 6'd1;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
        // LD follows the next scroll index so display and index change together.
        ld_d      = pick_byte(led_regs, scroll_d);
        cur_idx_d = scroll_d;
      end
      ST_STICKY: begin
        cur_idx_d = idx;
        if (idx_in_range) begin
          // A clear reloads from the current byte rather than zeroing, so a
          // bit arriving on the clear cycle survives.
          sticky_d = (entering || (idx != sw_p_idx_q)) ? idx_byte
                                                       : (sticky_q | idx_byte);
          ld_d     = sticky_d;
        end else begin
          ld_d = ~buttons[7:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: every register here, including the synchroniser, has a reset
    // value so LD and cur_idx come up defined in STATIC mode at index 0.
    if (!rst_b) begin
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      sw_p_idx_q <= '0;
      presc_q    <= '0;
      scroll_q   <= '0;
      sticky_q   <= '0;
      ld_q       <= '0;
      cur_idx_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, which is what makes the sync chain two stages.
      sw_meta_q  <= SW;
      sw_s_q     <= sw_meta_q;
      sw_p_idx_q <= sw_s_q[5:0];
      presc_q    <= presc_d;
      scroll_q   <= scroll_d;
      sticky_q   <= sticky_d;
      ld_q       <= ld_d;
      cur_idx_q  <= cur_idx_d;
    end
  end

  assign LD      = ld_q;
  assign cur_idx = cur_idx_q;

endmodule

// File: tb/tb_debug_led_scanner.sv
// Self-checking bench for debug_led_scanner: directed test-plan steps plus a
// randomized phase, every edge compared against a behavioural model.
module tb_debug_led_scanner;

  localparam int NUM_REGS   = 4;
  localparam int REG_W      = 32;
  localparam int SCROLL_DIV = 4;
  localparam int NUM_BYTES  = NUM_REGS * REG_W / 8;

  logic                      clk = 1'b0;
  logic                      rst_b;
  logic [7:0]                SW;
  logic [NUM_REGS*REG_W-1:0] led_regs;
  logic [15:0]               buttons;
  logic [7:0]                LD;
  logic [5:0]                cur_idx;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  debug_led_scanner #(
    .NUM_REGS  (NUM_REGS),
    .REG_W     (REG_W),
    .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .SW      (SW),
    .led_regs(led_regs),
    .buttons (buttons),
    .LD      (LD),
    .cur_idx (cur_idx)
  );

  // ---------------- behavioural reference model ----------------
  logic [31:0] regs [NUM_REGS];
  logic [7:0]  sync_q [$];   // [0] = synchronised SW, [1] = first stage
  logic [7:0]  m_sw_p;
  int          m_cnt;        // cycles spent in scroll mode since entry
  logic [7:0]  m_sticky;
  logic [7:0]  m_ld;
  logic [5:0]  m_cur;

  localparam logic [7:0] PLAN_BYTES [16] = '{
    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
    8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00
  };

  function automatic logic [7:0] byte_of(input int b);
    logic [31:0] w;
    w = regs[b / 4];
    return w[8*(b % 4) +: 8];
  endfunction

  task automatic set_reg(input int r, input logic [31:0] v);
    regs[r] = v;
    led_regs[r*32 +: 32] = v;
  endtask

  task automatic model_reset();
    sync_q   = '{8'h00, 8'h00};
    m_sw_p   = 8'h00;
    m_cnt    = 0;
    m_sticky = 8'h00;
    m_ld     = 8'h00;
    m_cur    = 6'd0;
  endtask

  task automatic model_edge();
    logic [7:0] ss;
    logic [5:0] idx;
    logic       in_range;
    logic       clear;
    int         si;
    ss       = sync_q[0];
    idx      = ss[5:0];
    in_range = (int'(idx) < NUM_BYTES);
    case (ss[7:6])
      2'b00: begin
        m_ld  = in_range ? byte_of(int'(idx)) : ~buttons[7:0];
        m_cur = idx;
      end
      2'b01: m_ld = ss[0] ? ~buttons[15:8] : ~buttons[7:0];
      2'b10: begin
        if (m_sw_p[7:6] != 2'b10) m_cnt = 0;
        else                      m_cnt++;
        si    = (m_cnt / SCROLL_DIV) % NUM_BYTES;
        m_ld  = byte_of(si);
        m_cur = 6'(si);
      end
      default: begin
        clear = (m_sw_p[7:6] != 2'b11) || (m_sw_p[5:0] != idx);
        if (in_range) begin
          m_sticky = clear ? byte_of(int'(idx)) : (m_sticky | byte_of(int'(idx)));
          m_ld     = m_sticky;
        end else begin
          m_ld = ~buttons[7:0];
        end
        m_cur = idx;
      end
    endcase
    m_sw_p = ss;
    void'(sync_q.pop_front());
    sync_q.push_back(SW);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check("model_ld", LD, m_ld);
      check("model_cur_idx", {2'b00, cur_idx}, {2'b00, m_cur});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    int hold;
    logic [1:0] md;
    logic [5:0] ix;

    rst_b   = 1'b0;
    SW      = 8'h00;
    buttons = 16'hFFFF;
    led_regs = '0;
    set_reg(0, 32'h44332211);
    set_reg(1, 32'h88776655);
    set_reg(2, 32'hCCBBAA99);
    set_reg(3, 32'h00FFEEDD);
    model_reset();

    #2;
    check("reset_ld", LD, 8'h00);
    check("reset_cur_idx", {2'b00, cur_idx}, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold_ld", LD, 8'h00);
    rst_b = 1'b1;
    tick(2);

    // static mode, in-range and out-of-range index
    SW = 8'h05;
    tick(3);
    check("static_idx5_ld", LD, 8'h66);
    check("static_idx5_cur", {2'b00, cur_idx}, 8'h05);
    buttons = 16'hFF7E;
    SW = 8'h10;
    tick(3);
    check("static_oor_ld", LD, 8'h81);

    // buttons mode, high and low byte
    buttons = 16'h5AFF;
    SW = 8'h41;
    tick(3);
    check("buttons_hi_ld", LD, 8'hA5);
    SW = 8'h40;
    tick(3);
    check("buttons_lo_ld", LD, 8'h00);
    check("buttons_cur_hold", {2'b00, cur_idx}, 8'h10);

    // auto-scroll: each byte held SCROLL_DIV cycles, wrap after byte 15
    SW = 8'h80;
    tick(2);
    for (int s = 0; s < 18; s++) begin
      for (int k = 0; k < SCROLL_DIV; k++) begin
        tick(1);
        check("scroll_seq", LD, PLAN_BYTES[s % 16]);
      end
    end

    // leave and re-enter scroll: restarts at byte 0
    SW = 8'h00;
    tick(4);
    SW = 8'h80;
    tick(3);
    check("scroll_reentry_ld", LD, 8'h11);
    check("scroll_reentry_cur", {2'b00, cur_idx}, 8'h00);

    // run to index 7, then reset asynchronously mid-scroll
    guard = 0;
    while (cur_idx !== 6'd7 && guard < 100) begin
      tick(1);
      guard++;
    end
    check("reach_idx7", {2'b00, cur_idx}, 8'h07);
    #2;
    rst_b = 1'b0;
    #1;
    check("async_reset_ld", LD, 8'h00);
    check("async_reset_cur", {2'b00, cur_idx}, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    tick(3);
    check("post_reset_scroll_ld", LD, 8'h11);
    check("post_reset_scroll_cur", {2'b00, cur_idx}, 8'h00);

    // 10 -> 11 -> 10 within two cycles: prescaler restarts on re-entry
    tick(6);
    SW = 8'hC0;
    tick(1);
    SW = 8'h80;
    tick(2);
    for (int k = 0; k < SCROLL_DIV; k++) begin
      tick(1);
      check("toggle_restart_hold", LD, 8'h11);
    end
    tick(1);
    check("toggle_restart_step", LD, 8'h22);

    // sticky accumulation of transient bits
    set_reg(0, 32'h44332200);
    SW = 8'hC0;
    tick(4);
    check("sticky_entry_ld", LD, 8'h00);
    set_reg(0, 32'h44332201);
    tick(1);
    set_reg(0, 32'h44332200);
    tick(3);
    set_reg(0, 32'h44332280);
    tick(1);
    set_reg(0, 32'h44332200);
    tick(3);
    check("sticky_accum_ld", LD, 8'h81);
    set_reg(0, 32'h44332204);
    SW = 8'hC1;
    tick(3);
    check("sticky_idx1_ld", LD, 8'h22);
    SW = 8'hC0;
    tick(3);
    check("sticky_clear_ld", LD, 8'h04);
    SW = 8'hD5;
    buttons = 16'h1234;
    tick(3);
    check("sticky_oor_ld", LD, 8'hCB);

    // randomized phase
    for (int it = 0; it < 250; it++) begin
      md = 2'($urandom_range(0, 3));
      ix = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                       : 6'($urandom_range(0, 17));
      SW      = {md, ix};
      buttons = 16'($urandom);
      if ($urandom_range(0, 2) == 0) set_reg($urandom_range(0, 3), $urandom);
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        if ($urandom_range(0, 3) == 0) begin
          set_reg(0, {regs[0][31:8], 8'($urandom)});
          buttons = 16'($urandom);
        end
        tick(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/debug_led_scanner.md
# debug_led_scanner

Parametrised successor to the board's combinational debug LED mux. It selects one byte out of NUM_REGS debug registers (or the controller button state) for the 8 board LEDs. It adds three sequential behaviours: switch synchronisation, a timed auto-scroll through all bytes, and a sticky mode that accumulates transient bits. It sits in the top level beside the MMIO debug registers and the controller interface, on the GBA system clock.

## Interface
- NUM_REGS, 4: number of 32-bit-or-wider debug registers; NUM_BYTES = NUM_REGS*REG_W/8, legal range 1..64.
- REG_W, 32: width of each debug register; must be a multiple of 8.
- SCROLL_DIV, 16777216: clk cycles per auto-scroll step (≥2).
- clk  in  1  GBA system clock. One clock; all logic in this domain.
- rst_b  in  1  reset, asynchronous, active-low.
- SW  in  8  board switches, asynchronous to clk.
- led_regs  in  NUM_REGS*REG_W  flattened debug registers, register i at bits [i*REG_W +: REG_W], synchronous to clk.
- buttons  in  16  controller state, active-low, synchronous to clk.
- LD  out  8  LED drive, registered.
- cur_idx  out  6  byte index currently displayed (valid in modes 00, 10, 11), registered.

## Operation
- SW passes through a 2-flop synchroniser; sw_s denotes the synchronised value and sw_p its previous-cycle copy.
- Byte b of the register space is led_regs[b*8 +: 8]. Bytes are ordered register 0 first, little-endian within each register.
- Mode = sw_s[7:6]; index field = sw_s[5:0].
- Mode 00, static: cur_idx = index. LD = byte[index] if index < NUM_BYTES, otherwise ~buttons[7:0].
- Mode 01, buttons: LD = sw_s[0] ? ~buttons[15:8] : ~buttons[7:0]. cur_idx holds its last value.
- Mode 10, auto-scroll:
  - A prescaler counts 0..SCROLL_DIV-1.
  - When the prescaler is at SCROLL_DIV-1 it wraps to 0 and scroll_idx advances, wrapping from NUM_BYTES-1 to 0.
  - LD = byte[scroll_idx]; cur_idx = scroll_idx.
  - On entry to mode 10 (mode != 10 in sw_p) the prescaler and scroll_idx load 0.
- Mode 11, sticky: sticky register S, 8 bits.
  - A clear event is entry to mode 11, or any change of the index field while in mode 11.
  - On a clear event S loads byte[index]; it is not zeroed, so the bits present on that cycle are kept.
  - Otherwise S <= S | byte[index].
  - LD = S; cur_idx = index.
  - If index ≥ NUM_BYTES, LD = ~buttons[7:0] and S holds its value.
- State machine over mode (STATIC, BUTTONS, SCROLL, STICKY). Transitions follow sw_s[7:6] directly; entry actions are as listed above. Leaving SCROLL or STICKY freezes their internal registers, which are not cleared until the next entry.
- Reset values: LD=0, cur_idx=0, prescaler=0, scroll_idx=0, S=0, both sync stages=0 (mode STATIC, index 0).

## Timing
- Output latency:
  - led_regs/buttons change → LD updates on the next clk edge (1 cycle).
  - SW change → LD reflects it on the 3rd clk edge (2 sync + 1 output).
- The scroll step is exactly SCROLL_DIV cycles. The first step after mode entry occurs SCROLL_DIV cycles after the entry edge.
- A clear event and a set bit on the same cycle: the set bit is kept in S.
- A simultaneous mode entry and index change counts as a single clear event.
- rst_b asserted mid-scroll or mid-accumulation clears all state immediately (async). Deassertion is synchronised externally; the block resumes in mode STATIC until sw_s propagates.

## Test plan
- NUM_REGS=4, regs = 0x44332211, 0x88776655, 0xCCBBAA99, 0x00FFEEDD; SW=0x05 → after 3 edges LD=0x66, cur_idx=5. SW=0x10 (idx 16 ≥ 16), buttons=0xFF7E → LD=0x81.
- SW=0x41 with buttons=0x5AFF → LD=0xA5. SW=0x40 → LD=0x00.
- SCROLL_DIV=4, SW=0x80 → LD shows 0x11, 0x22, 0x33… each held exactly 4 cycles. After byte 15 (0x00) it wraps to 0x11. Re-entering mode 10 restarts at 0x11.
- Sticky: SW=0xC0, reg0 byte0 pulses 0x01 for 1 cycle, later 0x80 for 1 cycle → LD=0x81 and held. Changing index to 1 then back to 0 → LD shows the current byte0 value only.
- Assert rst_b=0 mid-scroll at cur_idx=7 → LD=0, cur_idx=0 on the same cycle. Release with SW=0x80 held → scroll restarts from index 0.
- Toggle SW[7:6] 10→11→10 within 2 cycles: no glitch beyond the synchronised sequence, and the scroll prescaler restarts on the second entry.
